// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: load-use stalls, EX forwarding selects, memory-busy freeze with deferred branch flush.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_unit_mc #(
    parameter int REG_W           = 3,
    parameter int N_SRC           = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    input  logic [N_SRC*REG_W-1:0] id_rs,
    input  logic [N_SRC-1:0]       id_rs_valid,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [N_SRC*REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0]       mem_rd,
    input  logic                   mem_reg_write,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic                   wb_reg_write,
    output logic                   stall_fetch,
    output logic                   stall_decode,
    output logic                   pc_write,
    output logic                   bubble_ex,
    output logic                   freeze,
    output logic                   flush_fetch,
    output logic                   flush_decode,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0]       perf_stall_cnt,
    output logic [CNT_W-1:0]       perf_flush_cnt,
`endif
    output logic [2*N_SRC-1:0]     fwd_sel
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        MEM_FREEZE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LOAD_USE_CYCLES - 1);

    state_t     state_r;
    state_t     ret_state_r;
    logic [3:0] cnt_r;
    logic       flush_pend_r;

    state_t     state_nxt_s;
    state_t     ret_state_nxt_s;
    state_t     eff_state_s;
    logic [3:0] cnt_nxt_s;
    logic       flush_pend_nxt_s;

    logic                lu_hit_s;
    logic                stall_s;
    logic                bubble_s;
    logic                freeze_s;
    logic                flush_s;
    logic [2*N_SRC-1:0]  fwd_s;

    // Load-use detection across every used decode-stage source
    always_comb begin
        lu_hit_s = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            lu_hit_s = lu_hit_s | (id_rs_valid[i] & (id_rs[i*REG_W +: REG_W] == ex_rd));
        end
        lu_hit_s = lu_hit_s & ex_mem_read & ex_reg_write;
    end

    // Per-source forwarding select; the younger MEM result wins over WB
    always_comb begin
        fwd_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mem_reg_write && (mem_rd == ex_rs[i*REG_W +: REG_W])) begin
                fwd_s[2*i +: 2] = 2'b01;
            end else if (wb_reg_write && (wb_rd == ex_rs[i*REG_W +: REG_W])) begin
                fwd_s[2*i +: 2] = 2'b10;
            end else begin
                fwd_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Control outputs and next state: mem_busy beats flush beats load-use
    always_comb begin
        stall_s          = 1'b0;
        bubble_s         = 1'b0;
        freeze_s         = 1'b0;
        flush_s          = 1'b0;
        state_nxt_s      = state_r;
        ret_state_nxt_s  = ret_state_r;
        cnt_nxt_s        = cnt_r;
        flush_pend_nxt_s = flush_pend_r;

        // Leaving a freeze without a pending flush resumes the interrupted state this same cycle
        if ((state_r == MEM_FREEZE) && !mem_busy && !flush_pend_r) begin
            eff_state_s = ret_state_r;
        end else begin
            eff_state_s = state_r;
        end

        case (eff_state_s)
            RUN: begin
                if (mem_busy) begin
                    freeze_s         = 1'b1;
                    stall_s          = 1'b1;
                    ret_state_nxt_s  = RUN;
                    flush_pend_nxt_s = branch_taken;
                    state_nxt_s      = MEM_FREEZE;
                end else if (branch_taken) begin
                    flush_s     = 1'b1;
                    state_nxt_s = RUN;
                end else if (lu_hit_s) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        cnt_nxt_s   = CNT_INIT;
                        state_nxt_s = LU_STALL;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    freeze_s         = 1'b1;
                    stall_s          = 1'b1;
                    ret_state_nxt_s  = LU_STALL;
                    flush_pend_nxt_s = branch_taken;
                    state_nxt_s      = MEM_FREEZE;
                end else if (branch_taken) begin
                    flush_s     = 1'b1;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = RUN;
                end else begin
                    stall_s   = 1'b1;
                    bubble_s  = 1'b1;
                    cnt_nxt_s = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LU_STALL;
                    end
                end
            end
            MEM_FREEZE: begin
                if (mem_busy) begin
                    freeze_s         = 1'b1;
                    stall_s          = 1'b1;
                    flush_pend_nxt_s = flush_pend_r | branch_taken;
                    state_nxt_s      = MEM_FREEZE;
                end else begin
                    flush_s          = 1'b1;
                    flush_pend_nxt_s = 1'b0;
                    cnt_nxt_s        = 4'd0;
                    state_nxt_s      = RUN;
                end
            end
            default: begin
                state_nxt_s      = RUN;
                ret_state_nxt_s  = RUN;
                cnt_nxt_s        = 4'd0;
                flush_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Reset level masks the outputs so they settle without waiting for a clock edge
    assign stall_fetch  = rst_n & stall_s;
    assign stall_decode = rst_n & stall_s;
    assign pc_write     = ~stall_fetch;
    assign bubble_ex    = rst_n & bubble_s;
    assign freeze       = rst_n & freeze_s;
    assign flush_fetch  = rst_n & flush_s;
    assign flush_decode = rst_n & flush_s;
    assign fwd_sel      = rst_n ? fwd_s : '0;

    // FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RUN;
            ret_state_r  <= RUN;
            cnt_r        <= 4'd0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ret_state_r  <= ret_state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating performance counters, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_fetch && (perf_stall_cnt != {CNT_W{1'b1}})) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (flush_fetch && (perf_flush_cnt != {CNT_W{1'b1}})) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end else begin
                perf_flush_cnt <= perf_flush_cnt;
            end
        end
    end
`endif

endmodule
